// File: rtl/ext_bus_responder.sv
// ext_bus_responder: responder end of the 32-bit external memory bus.
// Decodes a command word on the first enabled cycle, absorbs write bursts
// into an internal word store and returns read bursts after a fixed
// turnaround. Every output comes straight from a flop.
module ext_bus_responder #(
    parameter int DEPTH     = 1024,
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IN_EXT_en,
    input  logic [31:0] IN_EXT_bus,
    output logic        OUT_EXT_oen,
    output logic [31:0] OUT_EXT_bus,
    output logic        OUT_busy,
    output logic        OUT_abort
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_WAIT_LOW
    } state_e;

    state_e          state_q, state_d;
    logic            en_q, en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            oen_q, oen_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            abort_q, abort_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [AW-1:0]   mem_raddr;
    logic [31:0]     mem [DEPTH];

    logic            is_cmd;
    logic            beat_last;
    logic            turn_last;

    assign is_cmd    = IN_EXT_en && !en_q;
    assign beat_last = (cnt_q == CW'(BURST_LEN - 1));
    assign turn_last = (cnt_q == CW'(LATENCY - 1));

    // Read address: word 0 while finishing the turnaround, next word while reading.
    always_comb begin
        mem_raddr = addr_q;
        if (state_q == S_READ) begin
            mem_raddr = addr_q + AW'(cnt_q + CW'(1));
        end
    end

    // Next-state, next-output and store-write decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        en_d      = IN_EXT_en;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        oen_d     = 1'b0;
        rdata_d   = 32'h0;
        abort_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q + AW'(cnt_q);

        case (state_q)
            S_IDLE: begin
                if (is_cmd) begin
                    addr_d  = IN_EXT_bus[AW-1:0];
                    cnt_d   = '0;
                    state_d = IN_EXT_bus[31] ? S_WRITE : S_TURN;
                end
            end
            S_WRITE: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    if (beat_last) begin
                        state_d = S_WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_TURN: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (turn_last) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    oen_d   = 1'b1;
                    rdata_d = mem[mem_raddr];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_READ: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (beat_last) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    oen_d   = 1'b1;
                    rdata_d = mem[mem_raddr];
                end
            end
            S_WAIT_LOW: begin
                if (!IN_EXT_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers; reset takes effect immediately, even mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            oen_q   <= 1'b0;
            rdata_q <= 32'h0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            oen_q   <= oen_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    // Word store write port.
    always_ff @(posedge clk) begin
        // NOTE: the store has no reset so its contents survive rst_n and it maps onto RAM.
        if (mem_we) begin
            mem[mem_waddr] <= IN_EXT_bus;
        end
    end

    assign OUT_EXT_oen = oen_q;
    assign OUT_EXT_bus = rdata_q;
    assign OUT_busy    = busy_q;
    assign OUT_abort   = abort_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed self-checking bench for ext_bus_responder (DEPTH=1024,
// BURST_LEN=4, LATENCY=2). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
module tb_ext_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] bus;
    logic        oen;
    logic [31:0] rdata;
    logic        busy;
    logic        abort;

    int total;
    int bad;

    ext_bus_responder #(
        .DEPTH    (1024),
        .BURST_LEN(4),
        .LATENCY  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IN_EXT_en  (en),
        .IN_EXT_bus (bus),
        .OUT_EXT_oen(oen),
        .OUT_EXT_bus(rdata),
        .OUT_busy   (busy),
        .OUT_abort  (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs, cross the rising edge, settle.
    task automatic cyc(input logic e, input logic [31:0] b);
        en  = e;
        bus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] cmd, input logic [31:0] d [4]);
        cyc(1'b1, cmd);
        check("wr_busy_start", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, d[i]);
        end
        check("wr_busy_end", {31'h0, busy}, 32'h1);
        check("wr_oen", {31'h0, oen}, 32'h0);
        cyc(1'b0, 32'h0);
        check("wr_idle", {31'h0, busy}, 32'h0);
    endtask

    // Read burst checked cycle by cycle; only the first n words are compared.
    task automatic do_read(input logic [31:0] cmd, input logic [31:0] e [4], input int n);
        cyc(1'b1, cmd);
        for (int i = 0; i < 2; i++) begin
            check("rd_turn_oen", {31'h0, oen}, 32'h0);
            check("rd_turn_bus", rdata, 32'h0);
            cyc(1'b1, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            check("rd_data_oen", {31'h0, oen}, 32'h1);
            if (i < n) check($sformatf("rd_data%0d", i), rdata, e[i]);
            cyc(1'b1, 32'h0);
        end
        check("rd_post_oen", {31'h0, oen}, 32'h0);
        check("rd_post_bus", rdata, 32'h0);
        check("rd_post_busy", {31'h0, busy}, 32'h1);
        cyc(1'b0, 32'h0);
        check("rd_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        bus   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_oen", {31'h0, oen}, 32'h0);
        check("rst_bus", rdata, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_abort", {31'h0, abort}, 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0);

        // Basic write then read.
        do_write(32'h8000_0010, '{32'h11, 32'h22, 32'h33, 32'h44});
        do_read(32'h0000_0010, '{32'h11, 32'h22, 32'h33, 32'h44}, 4);

        // Address wrap at the top of the store.
        do_write(32'h8000_03FE, '{32'hA, 32'hB, 32'hC, 32'hD});
        do_read(32'h0000_0000, '{32'hC, 32'hD, 32'h0, 32'h0}, 2);
        do_read(32'h0000_03FE, '{32'hA, 32'hB, 32'hC, 32'hD}, 4);

        // Upper address bits (and the reserved bit 30) are ignored.
        do_write(32'h8000_0410, '{32'hE0, 32'hE1, 32'hE2, 32'hE3});
        do_read(32'h4000_0010, '{32'hE0, 32'hE1, 32'hE2, 32'hE3}, 4);

        // Abort in the second read beat.
        cyc(1'b1, 32'h0000_0010);
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h0);
        check("ab_rd_beat0", rdata, 32'hE0);
        cyc(1'b1, 32'h0);
        check("ab_rd_beat1", rdata, 32'hE1);
        cyc(1'b0, 32'h0);
        check("ab_rd_oen", {31'h0, oen}, 32'h0);
        check("ab_rd_bus", rdata, 32'h0);
        check("ab_rd_abort", {31'h0, abort}, 32'h1);
        check("ab_rd_busy", {31'h0, busy}, 32'h0);
        cyc(1'b0, 32'h0);
        check("ab_rd_abort_drop", {31'h0, abort}, 32'h0);

        // Abort in write beat 2: words 0,1 new, words 2,3 keep old data.
        do_write(32'h8000_0020, '{32'h100, 32'h101, 32'h102, 32'h103});
        cyc(1'b1, 32'h8000_0020);
        cyc(1'b1, 32'h200);
        cyc(1'b1, 32'h201);
        cyc(1'b0, 32'h202);
        check("ab_wr_abort", {31'h0, abort}, 32'h1);
        check("ab_wr_busy", {31'h0, busy}, 32'h0);
        cyc(1'b0, 32'h0);
        check("ab_wr_abort_drop", {31'h0, abort}, 32'h0);
        do_read(32'h0000_0020, '{32'h200, 32'h201, 32'h102, 32'h103}, 4);

        // en held high after a write burst starts nothing new.
        cyc(1'b1, 32'h8000_0030);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h300 + i);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h0000_0010);
            check("hold_busy", {31'h0, busy}, 32'h1);
            check("hold_oen", {31'h0, oen}, 32'h0);
        end
        cyc(1'b0, 32'h0);
        check("hold_release", {31'h0, busy}, 32'h0);
        do_read(32'h0000_0030, '{32'h300, 32'h301, 32'h302, 32'h303}, 4);

        // Reset mid-read clears outputs at once; the store survives.
        cyc(1'b1, 32'h0000_03FE);
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h0);
        cyc(1'b1, 32'h0);
        check("mr_pre_oen", {31'h0, oen}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_oen", {31'h0, oen}, 32'h0);
        check("mr_bus", rdata, 32'h0);
        check("mr_busy", {31'h0, busy}, 32'h0);
        cyc(1'b0, 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0);
        do_read(32'h0000_03FE, '{32'hA, 32'hB, 32'hC, 32'hD}, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
